// File: rtl/approx_adder_error_monitor16.sv
// Error-statistics collector for 16-bit approximate adders: recomputes the exact sum per
// accepted sample and accumulates count, erroneous count, summed and maximum error distance.
module approx_adder_error_monitor16 #(
    parameter int WIDTH  = 16,
    parameter int CNT_W  = 32,
    parameter int ACC_W  = 40,
    parameter int WINDOW = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             clear_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   approx_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] samples_o,
    output logic [CNT_W-1:0] errors_o,
    output logic [ACC_W-1:0] sum_ed_o,
    output logic [WIDTH:0]   max_ed_o
);

    // state | meaning
    // IDLE  | waiting for start, statistics held
    // RUN   | accepting samples until window full or stop
    // DRAIN | no new samples, pipeline emptying
    // DONE  | statistics final, held until restart or clear
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int AC_W = 32;
    localparam logic [AC_W-1:0] WIN_C = AC_W'(WINDOW);

    state_t state_q, state_d;
    logic   busy_q, done_q;
    logic   start_run, accept;

    logic [AC_W-1:0]  accept_cnt_q, accept_cnt_d;
    logic             s1_v_q, s2_v_q;
    logic [WIDTH:0]   s1_ed_q, s2_ed_q;
    logic             s2_err_q;
    logic [WIDTH:0]   exact, ed;

    logic [CNT_W-1:0] samples_q, samples_d;
    logic [CNT_W-1:0] errors_q, errors_d;
    logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
    logic [WIDTH:0]   max_ed_q, max_ed_d;
    logic [ACC_W:0]   sum_ext;

    // State register; busy/done registered from the next state so they are glitch-free levels.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign start_run = start_i && !clear_i && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_i) state_d = S_RUN;
                S_RUN:   if (stop_i || ((WINDOW != 0) && (accept_cnt_q >= WIN_C))) state_d = S_DRAIN;
                // stage 2 retires on this same edge, so stage 1 empty means statistics are final
                S_DRAIN: if (!s1_v_q) state_d = S_DONE;
                S_DONE:  if (start_i) state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == S_RUN) && ((WINDOW == 0) || (accept_cnt_q < WIN_C));
        busy_o  = busy_q;
        done_o  = done_q;
    end

    assign accept = valid_i && ready_o;

    always_comb begin
        accept_cnt_d = accept_cnt_q;
        if (clear_i || start_run) accept_cnt_d = '0;
        else if (accept)          accept_cnt_d = accept_cnt_q + AC_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) accept_cnt_q <= '0;
        else       accept_cnt_q <= accept_cnt_d;
    end

    assign exact = {1'b0, add1_i} + {1'b0, add2_i};
    assign ed    = (exact >= approx_i) ? (exact - approx_i) : (approx_i - exact);

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            s1_v_q   <= 1'b0;
            s2_v_q   <= 1'b0;
            s1_ed_q  <= '0;
            s2_ed_q  <= '0;
            s2_err_q <= 1'b0;
        end else begin
            s1_v_q   <= accept;
            s2_v_q   <= s1_v_q;
            if (accept) s1_ed_q <= ed;
            if (s1_v_q) begin
                s2_ed_q  <= s1_ed_q;
                s2_err_q <= (s1_ed_q != '0);
            end
        end
    end

    assign sum_ext = {1'b0, sum_ed_q} + (ACC_W + 1)'(s2_ed_q);

    always_comb begin
        samples_d = samples_q;
        errors_d  = errors_q;
        sum_ed_d  = sum_ed_q;
        max_ed_d  = max_ed_q;
        if (clear_i || start_run) begin
            samples_d = '0;
            errors_d  = '0;
            sum_ed_d  = '0;
            max_ed_d  = '0;
        end else if (s2_v_q) begin
            if (samples_q != '1)            samples_d = samples_q + CNT_W'(1);
            if (s2_err_q && errors_q != '1) errors_d  = errors_q + CNT_W'(1);
            sum_ed_d = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            if (s2_ed_q > max_ed_q)         max_ed_d  = s2_ed_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samples_q <= '0;
            errors_q  <= '0;
            sum_ed_q  <= '0;
            max_ed_q  <= '0;
        end else begin
            samples_q <= samples_d;
            errors_q  <= errors_d;
            sum_ed_q  <= sum_ed_d;
            max_ed_q  <= max_ed_d;
        end
    end

    assign samples_o = samples_q;
    assign errors_o  = errors_q;
    assign sum_ed_o  = sum_ed_q;
    assign max_ed_o  = max_ed_q;

endmodule

// File: tb/tb_approx_adder_error_monitor16.sv
// Directed bench: three monitor instances (window 4, window 2, 3-bit counters unbounded).
module tb_approx_adder_error_monitor16;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start, stop, clear, valid;
    logic [15:0] a, b;
    logic [16:0] r;

    logic        rdy4, busy4, done4;
    logic [31:0] smp4, err4;
    logic [39:0] sum4;
    logic [16:0] max4;

    logic        rdy2, busy2, done2;
    logic [31:0] smp2, err2;
    logic [39:0] sum2;
    logic [16:0] max2;

    logic        rdys, busys, dones;
    logic [2:0]  smps, errs;
    logic [39:0] sums;
    logic [16:0] maxs;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    approx_adder_error_monitor16 #(.WINDOW(4)) u_w4 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .stop_i(stop[0]), .clear_i(clear[0]),
        .valid_i(valid[0]), .ready_o(rdy4), .add1_i(a), .add2_i(b), .approx_i(r),
        .busy_o(busy4), .done_o(done4), .samples_o(smp4), .errors_o(err4),
        .sum_ed_o(sum4), .max_ed_o(max4));

    approx_adder_error_monitor16 #(.WINDOW(2)) u_w2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .stop_i(stop[1]), .clear_i(clear[1]),
        .valid_i(valid[1]), .ready_o(rdy2), .add1_i(a), .add2_i(b), .approx_i(r),
        .busy_o(busy2), .done_o(done2), .samples_o(smp2), .errors_o(err2),
        .sum_ed_o(sum2), .max_ed_o(max2));

    approx_adder_error_monitor16 #(.CNT_W(3), .WINDOW(0)) u_sat (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .stop_i(stop[2]), .clear_i(clear[2]),
        .valid_i(valid[2]), .ready_o(rdys), .add1_i(a), .add2_i(b), .approx_i(r),
        .busy_o(busys), .done_o(dones), .samples_o(smps), .errors_o(errs),
        .sum_ed_o(sums), .max_ed_o(maxs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
    endtask

    task automatic set_data(input logic [15:0] x, input logic [15:0] y, input logic [16:0] z);
        a = x; b = y; r = z;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        checks++; if (smp4 !== 32'd0) begin failures++; $display("FAIL reset_samples got=%0h exp=0", smp4); end
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b done=%b exp=0,0", busy4, done4); end
        checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", rdy4); end
        checks++; if (max4 !== 17'd0 || sum4 !== 40'd0) begin failures++; $display("FAIL reset_stats got max=%0h sum=%0h exp=0,0", max4, sum4); end
    endtask

    task automatic test_window_run();
        logic [15:0] va [4] = '{16'h0000, 16'h29AF, 16'h1100, 16'h5555};
        logic [15:0] vb [4] = '{16'h0000, 16'h7A1B, 16'h1111, 16'hAAAA};
        logic [16:0] vr [4] = '{17'h00000, 17'h0A3BF, 17'h02211, 17'h0FFFF};
        pulse_start(0);
        checks++; if (busy4 !== 1'b1 || rdy4 !== 1'b1) begin failures++; $display("FAIL win_start got busy=%b ready=%b exp=1,1", busy4, rdy4); end
        valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_data(va[i], vb[i], vr[i]);
            tick();
        end
        valid[0] = 1'b0;
        checks++; if (rdy4 !== 1'b0) begin failures++; $display("FAIL win_ready_full got=%b exp=0", rdy4); end
        tick();
        checks++; if (done4 !== 1'b0 || busy4 !== 1'b1) begin failures++; $display("FAIL win_drain got done=%b busy=%b exp=0,1", done4, busy4); end
        tick();
        checks++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin failures++; $display("FAIL win_done got done=%b busy=%b exp=1,0", done4, busy4); end
        checks++; if (smp4 !== 32'd4) begin failures++; $display("FAIL win_samples got=%0d exp=4", smp4); end
        checks++; if (err4 !== 32'd1) begin failures++; $display("FAIL win_errors got=%0d exp=1", err4); end
        checks++; if (sum4 !== 40'd11) begin failures++; $display("FAIL win_sum got=%0d exp=11", sum4); end
        checks++; if (max4 !== 17'd11) begin failures++; $display("FAIL win_max got=%0d exp=11", max4); end
        tick();
        checks++; if (done4 !== 1'b1 || smp4 !== 32'd4) begin failures++; $display("FAIL win_hold got done=%b samples=%0d exp=1,4", done4, smp4); end
    endtask

    task automatic test_abs_max();
        pulse_start(0);
        checks++; if (smp4 !== 32'd0 || done4 !== 1'b0) begin failures++; $display("FAIL abs_rezero got samples=%0d done=%b exp=0,0", smp4, done4); end
        valid[0] = 1'b1;
        set_data(16'h8943, 16'hFFFF, 17'h18950); tick();
        set_data(16'hFFFF, 16'hFFFF, 17'h00000); tick();
        valid[0] = 1'b0;
        stop[0] = 1'b1; tick(); stop[0] = 1'b0;
        checks++; if (busy4 !== 1'b1 || rdy4 !== 1'b0) begin failures++; $display("FAIL abs_drain got busy=%b ready=%b exp=1,0", busy4, rdy4); end
        tick();
        checks++; if (done4 !== 1'b1) begin failures++; $display("FAIL abs_done got=%b exp=1", done4); end
        checks++; if (max4 !== 17'h1FFFE) begin failures++; $display("FAIL abs_max got=%0h exp=1fffe", max4); end
        checks++; if (sum4 !== 40'h2000C) begin failures++; $display("FAIL abs_sum got=%0h exp=2000c", sum4); end
        checks++; if (err4 !== 32'd2 || smp4 !== 32'd2) begin failures++; $display("FAIL abs_counts got err=%0d smp=%0d exp=2,2", err4, smp4); end
    endtask

    task automatic test_latency();
        pulse_start(0);
        valid[0] = 1'b1;
        set_data(16'h0003, 16'h0004, 17'h00007);
        tick();
        valid[0] = 1'b0;
        checks++; if (smp4 !== 32'd0) begin failures++; $display("FAIL lat_n got=%0d exp=0", smp4); end
        tick();
        checks++; if (smp4 !== 32'd0) begin failures++; $display("FAIL lat_n1 got=%0d exp=0", smp4); end
        tick();
        checks++; if (smp4 !== 32'd1) begin failures++; $display("FAIL lat_n2 got=%0d exp=1", smp4); end
        clear[0] = 1'b1; tick(); clear[0] = 1'b0;
    endtask

    task automatic test_backpressure();
        pulse_start(1);
        valid[1] = 1'b1;
        set_data(16'h0001, 16'h0001, 17'h00002); tick();
        checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", rdy2); end
        set_data(16'h0002, 16'h0002, 17'h00000); tick();
        checks++; if (rdy2 !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", rdy2); end
        set_data(16'h0003, 16'h0000, 17'h00000); tick();
        valid[1] = 1'b0;
        tick();
        checks++; if (done2 !== 1'b1) begin failures++; $display("FAIL bp_done got=%b exp=1", done2); end
        checks++; if (smp2 !== 32'd2 || sum2 !== 40'd4 || err2 !== 32'd1) begin failures++; $display("FAIL bp_stats got smp=%0d sum=%0d err=%0d exp=2,4,1", smp2, sum2, err2); end
    endtask

    task automatic test_saturation_stop();
        pulse_start(2);
        valid[2] = 1'b1;
        set_data(16'h0001, 16'h0000, 17'h00000);
        repeat (9) tick();
        valid[2] = 1'b0;
        stop[2] = 1'b1; tick(); stop[2] = 1'b0;
        checks++; if (busys !== 1'b1 || dones !== 1'b0) begin failures++; $display("FAIL sat_drain got busy=%b done=%b exp=1,0", busys, dones); end
        tick();
        checks++; if (dones !== 1'b1 || busys !== 1'b0) begin failures++; $display("FAIL sat_done got done=%b busy=%b exp=1,0", dones, busys); end
        checks++; if (smps !== 3'd7 || errs !== 3'd7) begin failures++; $display("FAIL sat_counts got smp=%0d err=%0d exp=7,7", smps, errs); end
        checks++; if (sums !== 40'd9 || maxs !== 17'd1) begin failures++; $display("FAIL sat_sum got sum=%0d max=%0d exp=9,1", sums, maxs); end
    endtask

    task automatic test_abort_clear();
        pulse_start(0);
        valid[0] = 1'b1;
        set_data(16'h0001, 16'h0000, 17'h00000);
        tick(); tick();
        clear[0] = 1'b1; tick(); clear[0] = 1'b0;
        valid[0] = 1'b0;
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0 || rdy4 !== 1'b0) begin failures++; $display("FAIL clr_state got busy=%b done=%b ready=%b exp=0,0,0", busy4, done4, rdy4); end
        checks++; if (smp4 !== 32'd0 || sum4 !== 40'd0) begin failures++; $display("FAIL clr_stats got smp=%0d sum=%0d exp=0,0", smp4, sum4); end
        tick(); tick();
        checks++; if (smp4 !== 32'd0 || err4 !== 32'd0 || max4 !== 17'd0) begin failures++; $display("FAIL clr_flush got smp=%0d err=%0d max=%0d exp=0,0,0", smp4, err4, max4); end
    endtask

    task automatic test_abort_reset();
        pulse_start(0);
        valid[0] = 1'b1;
        set_data(16'h0001, 16'h0000, 17'h00000);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        valid[0] = 1'b0;
        checks++; if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin failures++; $display("FAIL rst_state got busy=%b ready=%b exp=0,0", busy4, rdy4); end
        tick(); tick();
        checks++; if (smp4 !== 32'd0 || sum4 !== 40'd0) begin failures++; $display("FAIL rst_flush got smp=%0d sum=%0d exp=0,0", smp4, sum4); end
    endtask

    task automatic test_clear_start();
        clear[0] = 1'b1; start[0] = 1'b1;
        tick();
        clear[0] = 1'b0; start[0] = 1'b0;
        checks++; if (busy4 !== 1'b0 || rdy4 !== 1'b0) begin failures++; $display("FAIL clr_start got busy=%b ready=%b exp=0,0", busy4, rdy4); end
    endtask

    initial begin
        rst = 1'b1; start = '0; stop = '0; clear = '0; valid = '0;
        a = '0; b = '0; r = '0;
        test_reset();
        test_window_run();
        test_abs_max();
        test_latency();
        test_backpressure();
        test_saturation_stop();
        test_abort_clear();
        test_abort_reset();
        test_clear_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/approx_adder_error_monitor16.md
Name: approx_adder_error_monitor16

Overview:
Sequential error-statistics collector at the output side of the 16-bit approximate adders, e.g. the lower-part-OR ripple-carry adder.
- Per accepted sample: takes both operands plus the 17-bit approximate result, recomputes the exact sum, and accumulates error metrics: sample count, erroneous-sample count, summed error distance, maximum error distance.
- Runs over a programmable sample window under a small FSM; used in gate-level sims and on-FPGA characterisation.

Parameters:
WIDTH, 16, operand width; result width is WIDTH+1
CNT_W, 32, width of sample/error counters
ACC_W, 40, width of summed error-distance accumulator
WINDOW, 1024, samples per run; 0 = unbounded, run ends only on stop_i

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  one-cycle pulse: begin run from IDLE
stop_i  input  1  one-cycle pulse: end run early (RUN only)
clear_i  input  1  abort run, zero statistics, return to IDLE
valid_i  input  1  sample present on add1_i/add2_i/approx_i
ready_o  output  1  monitor accepts a sample this cycle
add1_i  input  WIDTH  operand A
add2_i  input  WIDTH  operand B
approx_i  input  WIDTH+1  approximate adder result for A,B
busy_o  output  1  FSM in RUN or DRAIN
done_o  output  1  FSM in DONE; statistics final
samples_o  output  CNT_W  samples accumulated
errors_o  output  CNT_W  samples with nonzero error distance
sum_ed_o  output  ACC_W  sum of error distances
max_ed_o  output  WIDTH+1  largest error distance seen

Behaviour:
- Reset:
  - rst_i high at an edge puts the FSM in IDLE and zeroes all outputs, the pipeline and the accept counter.
  - Reset mid-run discards in-flight samples.
- FSM states IDLE, RUN, DRAIN, DONE:
  - IDLE -> RUN on start_i. Statistics and accept counter zero on entry.
  - RUN -> DRAIN when the accept counter reaches WINDOW (WINDOW != 0), or on stop_i.
  - DRAIN -> DONE once pipeline stages 1 and 2 hold no valid sample; takes at most 2 cycles.
  - DONE -> RUN on start_i; statistics re-zeroed.
  - start_i in RUN or DRAIN is ignored.
- clear_i, any state: next edge IDLE, statistics zeroed, pipeline flushed.
  - Priority: rst_i > clear_i > stop_i > start_i.
- Handshake:
  - ready_o = state==RUN and (WINDOW==0 or accept_cnt < WINDOW); combinational from registered state only.
  - Sample accepted on an edge where valid_i && ready_o. Back-to-back accepts allowed, one per cycle.
  - valid_i while ready_o low: sample dropped, not counted.
- Pipeline:
  - Stage 1 registers exact = add1_i + add2_i (WIDTH+1 bits, zero-extended) and ed = |exact - approx_i| (WIDTH+1 bits, unsigned magnitude).
  - Stage 2 updates statistics:
    - samples+1
    - errors+1 if ed != 0
    - sum_ed += ed
    - max_ed = max(max_ed, ed)
  - Latency: sample accepted at edge N is visible on outputs after edge N+2.
- Saturation: samples_o, errors_o and sum_ed_o saturate at all-ones and never wrap. accept_cnt compares against WINDOW independently.
- done_o and busy_o are registered level outputs, mutually exclusive. Outputs hold their values in DONE and IDLE until restart, clear or reset.

Test Plan:
- Window run:
  - Setup: WINDOW=4; start, then 4 samples.
  - Samples (add1,add2,approx): (0000,0000,00000), (29AF,7A1B,0A3BF), (1100,1111,02211), (5555,AAAA,0FFFF).
  - Result: samples=4, errors=1, sum_ed=11, max_ed=11, done_o high 2-3 cycles after last accept.
- Absolute error and max:
  - Samples: (8943,FFFF,18950) -> ed=14; then (FFFF,FFFF,00000) -> ed=0x1FFFE.
  - Result: max_ed=0x1FFFE, sum_ed=0x2000C, errors=2.
- Backpressure:
  - Setup: WINDOW=2; valid_i held high 3 cycles.
  - Result: ready_o drops after the 2nd accept; 3rd sample ignored; samples=2.
- Latency:
  - Stimulus: single accept at edge N.
  - Result: samples_o=0 after N+1, =1 after N+2.
- Saturation and stop:
  - Setup: CNT_W=3, WINDOW=0; 9 erroneous samples, then stop_i.
  - Result: samples=7, errors=7; DRAIN then DONE.
- Abort:
  - clear_i after 2 of 4 samples -> IDLE, all stats 0, ready_o low.
  - Repeat with rst_i -> same result.
  - clear_i and start_i in the same cycle -> IDLE.
